// File: rtl/fpu_in_issue_queue_if.sv
// Request and FPU-issue channels of the FPU input issue queue.
// slave is the queue's view of the bus and master is the environment's view.
interface fpu_in_issue_queue_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [1:0]        req_rmode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic              fpu_start;
    logic [2:0]        fpu_op;
    logic [1:0]        fpu_rmode;
    logic [DATA_W-1:0] fpu_a;
    logic [DATA_W-1:0] fpu_b;
    logic [TAG_W-1:0]  fpu_tag;
    logic              fpu_done;

    modport master (
        output req_valid, req_op, req_rmode, req_a, req_b,
        input  req_ready,
        input  fpu_start, fpu_op, fpu_rmode, fpu_a, fpu_b, fpu_tag,
        output fpu_done
    );

    modport slave (
        input  req_valid, req_op, req_rmode, req_a, req_b,
        output req_ready,
        output fpu_start, fpu_op, fpu_rmode, fpu_a, fpu_b, fpu_tag,
        input  fpu_done
    );
endinterface

// File: rtl/fpu_in_issue_queue.sv
// FIFO-buffered issue stage for a non-pipelined FPU core, with a done watchdog.
// Define FPU_IN_ISSUE_OPCHECK_EN to drop and count requests whose opcode is above 4.
module fpu_in_issue_queue #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    fpu_in_issue_queue_if.slave      bus,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     timeout_err_o
`ifdef FPU_IN_ISSUE_OPCHECK_EN
    ,
    output logic                     illegal_op_o,
    output logic [7:0]               illegal_cnt_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [2:0]        mem_op_q    [DEPTH];
    logic [1:0]        mem_rmode_q [DEPTH];
    logic [DATA_W-1:0] mem_a_q     [DEPTH];
    logic [DATA_W-1:0] mem_b_q     [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [TAG_W-1:0]  tag_cnt_q;

    logic [2:0]        fpu_op_q;
    logic [1:0]        fpu_rmode_q;
    logic [DATA_W-1:0] fpu_a_q, fpu_b_q;
    logic [TAG_W-1:0]  fpu_tag_q;

    logic accept, op_legal, enq, pop, start, timeout;

    assign accept = bus.req_valid && (level_q != LVL_W'(DEPTH));
`ifdef FPU_IN_ISSUE_OPCHECK_EN
    assign op_legal = (bus.req_op <= 3'd4);
`else
    assign op_legal = 1'b1;
`endif
    assign enq = accept && op_legal && !flush_i;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        pop     = 1'b0;
        start   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over a watchdog expiring in the same cycle
                if (bus.fpu_done) begin
                    state_d = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            wd_d    = '0;
            pop     = 1'b0;
            start   = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tag_cnt_q   <= '0;
            fpu_op_q    <= '0;
            fpu_rmode_q <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_tag_q   <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({enq, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
            if (pop) begin
                fpu_op_q    <= mem_op_q[rd_ptr_q];
                fpu_rmode_q <= mem_rmode_q[rd_ptr_q];
                fpu_a_q     <= mem_a_q[rd_ptr_q];
                fpu_b_q     <= mem_b_q[rd_ptr_q];
                fpu_tag_q   <= tag_cnt_q;
                tag_cnt_q   <= tag_cnt_q + 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clock_i) begin
        if (enq) begin
            mem_op_q[wr_ptr_q]    <= bus.req_op;
            mem_rmode_q[wr_ptr_q] <= bus.req_rmode;
            mem_a_q[wr_ptr_q]     <= bus.req_a;
            mem_b_q[wr_ptr_q]     <= bus.req_b;
        end
    end

`ifdef FPU_IN_ISSUE_OPCHECK_EN
    logic       illegal_q;
    logic [7:0] illegal_cnt_q;
    logic       illegal_hit;

    assign illegal_hit = accept && !op_legal;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q <= illegal_hit;
            if (illegal_hit && (illegal_cnt_q != 8'hFF)) begin
                illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end
        end
    end

    assign illegal_op_o  = illegal_q;
    assign illegal_cnt_o = illegal_cnt_q;
`endif

    assign bus.req_ready = (level_q != LVL_W'(DEPTH));
    assign bus.fpu_start = start;
    assign bus.fpu_op    = fpu_op_q;
    assign bus.fpu_rmode = fpu_rmode_q;
    assign bus.fpu_a     = fpu_a_q;
    assign bus.fpu_b     = fpu_b_q;
    assign bus.fpu_tag   = fpu_tag_q;
    assign busy_o        = (state_q != IDLE);
    assign level_o       = level_q;
    assign timeout_err_o = timeout;
endmodule

// File: tb/tb_fpu_in_issue_queue.sv
// Scenario-based bench for fpu_in_issue_queue with random requests and a queue scoreboard.
module tb_fpu_in_issue_queue;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic [2:0]        op;
        logic [1:0]        rmode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    logic             clock_i  = 1'b0;
    logic             reset_ni = 1'b0;
    logic             flush_i  = 1'b0;
    logic             busy_o;
    logic             timeout_err_o;
    logic [LVL_W-1:0] level_o;
`ifdef FPU_IN_ISSUE_OPCHECK_EN
    logic             illegal_op_o;
    logic [7:0]       illegal_cnt_o;
`endif

    fpu_in_issue_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    fpu_in_issue_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_i       (clock_i),
        .reset_ni      (reset_ni),
        .flush_i       (flush_i),
        .bus           (bus),
        .busy_o        (busy_o),
        .level_o       (level_o),
        .timeout_err_o (timeout_err_o)
`ifdef FPU_IN_ISSUE_OPCHECK_EN
        ,
        .illegal_op_o  (illegal_op_o),
        .illegal_cnt_o (illegal_cnt_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   exp_tag = 0;
    req_t exp_q[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic step();
        @(posedge clock_i);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rmode = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.fpu_done  = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_ni = 1'b0;
        step();
        step();
        reset_ni = 1'b1;
        exp_q.delete();
        exp_tag = 0;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.op    = 3'($urandom_range(0, 4));
        r.rmode = 2'($urandom_range(0, 3));
        r.a     = {$urandom, $urandom};
        r.b     = {$urandom, $urandom};
        return r;
    endfunction

    task automatic drive_req(input req_t r);
        bus.req_valid = 1'b1;
        bus.req_op    = r.op;
        bus.req_rmode = r.rmode;
        bus.req_a     = r.a;
        bus.req_b     = r.b;
    endtask

    task automatic test_reset();
        req_t r;
        clear_inputs();
        reset_ni = 1'b0;
        drive_req(rand_req());
        step();
        step();
        checks++;
        if (busy_o !== 1'b0 || timeout_err_o !== 1'b0 || bus.fpu_start !== 1'b0 ||
            level_o !== '0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b to=%b start=%b level=%0d ready=%b, required 0 0 0 0 1",
                     busy_o, timeout_err_o, bus.fpu_start, level_o, bus.req_ready);
        end
        checks++;
        if (bus.fpu_op !== '0 || bus.fpu_rmode !== '0 || bus.fpu_a !== '0 ||
            bus.fpu_b !== '0 || bus.fpu_tag !== '0) begin
            errors++;
            $display("FAIL reset_data: op=%0d rm=%0d a=%h b=%h tag=%0d, required all zero",
                     bus.fpu_op, bus.fpu_rmode, bus.fpu_a, bus.fpu_b, bus.fpu_tag);
        end
        clear_inputs();
        reset_ni = 1'b1;
        // reset in the middle of an operation
        r = rand_req();
        r.a[63] = 1'b1;
        drive_req(r);
        step();
        clear_inputs();
        step();
        step();
        checks++;
        if (busy_o !== 1'b1 || bus.fpu_a !== r.a) begin
            errors++;
            $display("FAIL reset_mid_pre: busy=%b a=%h, required busy=1 a=%h", busy_o, bus.fpu_a, r.a);
        end
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        checks++;
        if (busy_o !== 1'b0 || level_o !== '0 || bus.fpu_a !== '0 || bus.fpu_b !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b level=%0d a=%h b=%h, required 0 0 0 0",
                     busy_o, level_o, bus.fpu_a, bus.fpu_b);
        end
        drive_req(rand_req());
        step();
        clear_inputs();
        step();
        checks++;
        if (bus.fpu_start !== 1'b1 || bus.fpu_tag !== '0) begin
            errors++;
            $display("FAIL reset_tag: start=%b tag=%0d, required start=1 tag=0", bus.fpu_start, bus.fpu_tag);
        end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_single();
        req_t r;
        do_reset();
        r.op = 3'd2; r.rmode = 2'd1; r.a = 64'h4000000000000000; r.b = 64'h4008000000000000;
        drive_req(r);
        step();
        clear_inputs();
        checks++;
        if (level_o !== LVL_W'(1) || bus.fpu_start !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: level=%0d start=%b, required level=1 start=0", level_o, bus.fpu_start);
        end
        step();
        checks++;
        if (bus.fpu_start !== 1'b1 || bus.fpu_tag !== '0 || bus.fpu_op !== 3'd2 || bus.fpu_rmode !== r.rmode ||
            bus.fpu_a !== r.a || bus.fpu_b !== r.b || busy_o !== 1'b1 || level_o !== '0) begin
            errors++;
            $display("FAIL single_issue: start=%b tag=%0d op=%0d rm=%0d a=%h b=%h busy=%b level=%0d, required 1 0 2 %0d %h %h 1 0",
                     bus.fpu_start, bus.fpu_tag, bus.fpu_op, bus.fpu_rmode, bus.fpu_a, bus.fpu_b,
                     busy_o, level_o, r.rmode, r.a, r.b);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (bus.fpu_start !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_wait: cycle %0d start=%b busy=%b, required 0 1", k, bus.fpu_start, busy_o);
            end
        end
        step();
        bus.fpu_done = 1'b1;
        step();
        bus.fpu_done = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: busy=%b, required 0", busy_o);
        end
        $display("test_single done: errors=%0d", errors);
    endtask

    task automatic test_timeout();
        req_t r;
        req_t e;
        int   start_cyc = -1;
        int   to_cyc    = -1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r = rand_req();
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL to_ready: req %0d ready=%b, required 1", i, bus.req_ready);
            end
            drive_req(r);
            exp_q.push_back(r);
            step();
            if (bus.fpu_start === 1'b1) begin
                start_cyc = cyc;
                e = exp_q.pop_front();
                checks++;
                if (bus.fpu_op !== e.op || bus.fpu_a !== e.a || bus.fpu_b !== e.b || bus.fpu_tag !== TAG_W'(exp_tag)) begin
                    errors++;
                    $display("FAIL to_issue0: op=%0d a=%h tag=%0d, required op=%0d a=%h tag=%0d",
                             bus.fpu_op, bus.fpu_a, bus.fpu_tag, e.op, e.a, exp_tag);
                end
                exp_tag++;
            end
        end
        clear_inputs();
        checks++;
        if (level_o !== LVL_W'(DEPTH) || bus.req_ready !== 1'b0 || start_cyc < 0) begin
            errors++;
            $display("FAIL to_full: level=%0d ready=%b started=%0d, required level=%0d ready=0 started=1",
                     level_o, bus.req_ready, start_cyc >= 0, DEPTH);
        end
        for (int c = 0; c < TIMEOUT + 10; c++) begin
            step();
            if (bus.fpu_start === 1'b1) begin
                errors++;
                $display("FAIL to_early_issue: start=1 during WAIT, required 0");
            end
            if (timeout_err_o === 1'b1) begin
                to_cyc = cyc;
                break;
            end
        end
        checks++;
        if (to_cyc - start_cyc != TIMEOUT) begin
            errors++;
            $display("FAIL to_latency: timeout_err at start+%0d, required start+%0d", to_cyc - start_cyc, TIMEOUT);
        end
        step();
        checks++;
        if (timeout_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: to=%b busy=%b, required 0 0", timeout_err_o, busy_o);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.fpu_start !== 1'b1 || bus.fpu_tag !== TAG_W'(exp_tag) || bus.fpu_op !== e.op || bus.fpu_a !== e.a) begin
            errors++;
            $display("FAIL to_next: start=%b tag=%0d op=%0d a=%h, required 1 %0d %0d %h",
                     bus.fpu_start, bus.fpu_tag, bus.fpu_op, bus.fpu_a, exp_tag, e.op, e.a);
        end
        exp_tag++;
        $display("test_timeout done: errors=%0d", errors);
    endtask

    task automatic test_seq20();
        req_t r;
        req_t e;
        bit   have      = 1'b0;
        int   sent      = 0;
        int   issued    = 0;
        int   start_cyc = -100;
        do_reset();
        for (int c = 0; c < 3000 && issued < 20; c++) begin
            step();
            if (bus.fpu_start === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seq_issue: unexpected start tag=%0d, required no start (queue empty)", bus.fpu_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.fpu_op !== e.op || bus.fpu_rmode !== e.rmode || bus.fpu_a !== e.a ||
                        bus.fpu_b !== e.b || bus.fpu_tag !== TAG_W'(exp_tag)) begin
                        errors++;
                        $display("FAIL seq_issue: op=%0d rm=%0d a=%h b=%h tag=%0d, required %0d %0d %h %h %0d",
                                 bus.fpu_op, bus.fpu_rmode, bus.fpu_a, bus.fpu_b, bus.fpu_tag,
                                 e.op, e.rmode, e.a, e.b, exp_tag % (1 << TAG_W));
                    end
                end
                exp_tag++;
                issued++;
                start_cyc = cyc;
            end
            checks++;
            if (level_o > LVL_W'(DEPTH) || timeout_err_o !== 1'b0) begin
                errors++;
                $display("FAIL seq_level: level=%0d to=%b, required level<=%0d to=0", level_o, timeout_err_o, DEPTH);
            end
            bus.fpu_done = (cyc == start_cyc + 3);
            if (!have && sent < 20 && $urandom_range(0, 2) != 0) begin
                r    = rand_req();
                have = 1'b1;
            end
            if (have) begin
                drive_req(r);
                if (bus.req_ready === 1'b1) begin
                    exp_q.push_back(r);
                    sent++;
                    have = 1'b0;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        clear_inputs();
        checks++;
        if (issued != 20) begin
            errors++;
            $display("FAIL seq_count: issued %0d ops, required 20", issued);
        end
        $display("test_seq20 done: errors=%0d", errors);
    endtask

    task automatic test_done_timeout_tie();
        int start_cyc = -1;
        do_reset();
        drive_req(rand_req());
        step();
        clear_inputs();
        step();
        if (bus.fpu_start === 1'b1) start_cyc = cyc;
        checks++;
        if (start_cyc < 0) begin
            errors++;
            $display("FAIL tie_start: start=%b, required 1", bus.fpu_start);
        end
        for (int c = 0; c < TIMEOUT + 5 && cyc < start_cyc + TIMEOUT; c++) begin
            step();
        end
        checks++;
        if (timeout_err_o !== 1'b1) begin
            errors++;
            $display("FAIL tie_armed: to=%b at start+%0d without done, required 1", timeout_err_o, cyc - start_cyc);
        end
        bus.fpu_done = 1'b1;
        #1;
        checks++;
        if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL tie_done_wins: to=%b busy=%b, required 0 1", timeout_err_o, busy_o);
        end
        step();
        bus.fpu_done = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: busy=%b to=%b, required 0 0", busy_o, timeout_err_o);
        end
        $display("test_done_timeout_tie done: errors=%0d", errors);
    endtask

    task automatic test_flush();
        req_t r;
        req_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            r = rand_req();
            drive_req(r);
            exp_q.push_back(r);
            step();
            if (bus.fpu_start === 1'b1) begin
                e = exp_q.pop_front();
                exp_tag++;
            end
        end
        clear_inputs();
        checks++;
        if (level_o !== LVL_W'(3) || busy_o !== 1'b1 || exp_tag != 1) begin
            errors++;
            $display("FAIL flush_pre: level=%0d busy=%b issues=%0d, required 3 1 1", level_o, busy_o, exp_tag);
        end
        flush_i = 1'b1;
        drive_req(rand_req());
        step();
        clear_inputs();
        exp_q.delete();
        checks++;
        if (level_o !== '0 || busy_o !== 1'b0 || bus.fpu_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: level=%0d busy=%b start=%b, required 0 0 0", level_o, busy_o, bus.fpu_start);
        end
        step();
        checks++;
        if (level_o !== '0 || busy_o !== 1'b0 || bus.fpu_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_stay: level=%0d busy=%b start=%b, required 0 0 0", level_o, busy_o, bus.fpu_start);
        end
        r = rand_req();
        drive_req(r);
        step();
        clear_inputs();
        step();
        checks++;
        if (bus.fpu_start !== 1'b1 || bus.fpu_tag !== TAG_W'(exp_tag) || bus.fpu_a !== r.a) begin
            errors++;
            $display("FAIL flush_tag: start=%b tag=%0d a=%h, required 1 %0d %h",
                     bus.fpu_start, bus.fpu_tag, bus.fpu_a, exp_tag, r.a);
        end
        exp_tag++;
        flush_i = 1'b1;
        #1;
        checks++;
        if (bus.fpu_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: start=%b during flush, required 0", bus.fpu_start);
        end
        step();
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue: busy=%b, required 0", busy_o);
        end
        $display("test_flush done: errors=%0d", errors);
    endtask

    task automatic test_illegal_op();
        req_t r;
        do_reset();
        r    = rand_req();
        r.op = 3'd6;
        drive_req(r);
        step();
        clear_inputs();
`ifdef FPU_IN_ISSUE_OPCHECK_EN
        checks++;
        if (illegal_op_o !== 1'b1 || illegal_cnt_o !== 8'd1 || level_o !== '0) begin
            errors++;
            $display("FAIL illegal_flag: pulse=%b cnt=%0d level=%0d, required 1 1 0",
                     illegal_op_o, illegal_cnt_o, level_o);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.fpu_start !== 1'b0 || illegal_op_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_quiet: start=%b pulse=%b busy=%b, required 0 0 0",
                         bus.fpu_start, illegal_op_o, busy_o);
            end
        end
`else
        step();
        checks++;
        if (bus.fpu_start !== 1'b1 || bus.fpu_op !== 3'd6 || bus.fpu_tag !== '0 || bus.fpu_a !== r.a) begin
            errors++;
            $display("FAIL illegal_verbatim: start=%b op=%0d tag=%0d a=%h, required 1 6 0 %h",
                     bus.fpu_start, bus.fpu_op, bus.fpu_tag, bus.fpu_a, r.a);
        end
`endif
        $display("test_illegal_op done: errors=%0d", errors);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_timeout();
        test_seq20();
        test_done_timeout_tie();
        test_flush();
        test_illegal_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
